alu_sched: RTL and testbench
============================

// Module: alu_sched
// PURPOSE
//  Two-requester scheduler that shares the single 4-bit add/sub/and/xor ALU.
//  - Arbitrates between two requesters with valid/ready handshakes.
//  - Registers the granted op and operands, then drives the ALU select/operand pins.
//  - Captures R/Cout/ovr plus derived zero/negative flags into a held response with
//    backpressure.
//  - Sits between the instruction-issue logic and the combinational ALU.
// PARAMETERS
//  WIDTH      4  operand/result width; must match ALU width
//  FIXED_PRIO 0  0 = round-robin arbitration, 1 = requester 0 always wins
// PORTS
//  clk          in   1      system clock, rising edge
//  rst          in   1      asynchronous, active-high reset
//  req_valid    in   2      per-requester request valid, bit i = requester i
//  req_ready    out  2      per-requester accept; at most one bit high
//  req_op0      in   2      requester 0 op {S1,S0}: 00 add, 01 sub, 10 and, 11 xor
//  req_a0       in   WIDTH  requester 0 operand A
//  req_b0       in   WIDTH  requester 0 operand B
//  req_op1      in   2      requester 1 op (same encoding as req_op0)
//  req_a1       in   WIDTH  requester 1 operand A
//  req_b1       in   WIDTH  requester 1 operand B
//  alu_a        out  WIDTH  to ALU A (registered)
//  alu_b        out  WIDTH  to ALU B (registered)
//  alu_s0       out  1      to ALU S0 (registered)
//  alu_s1       out  1      to ALU S1 (registered)
//  alu_r        in   WIDTH  from ALU R (combinational result)
//  alu_cout     in   1      from ALU Cout
//  alu_ovr      in   1      from ALU ovr
//  rsp_valid    out  1      response valid
//  rsp_ready    in   1      consumer accepts response
//  rsp_id       out  1      requester that owns the response
//  rsp_r        out  WIDTH  result
//  rsp_cout     out  1      carry; 0 for and/xor
//  rsp_ovr      out  1      signed overflow; 0 for and/xor
//  rsp_zero     out  1      rsp_r == 0
//  rsp_neg      out  1      rsp_r[WIDTH-1]
//  busy         out  1      state != IDLE
// BEHAVIOUR
//  Reset (async, rst=1):
//  - state=IDLE; all outputs 0; alu_* = 0; rr last_grant=1, so requester 0 wins the first tie.
//  - A reset mid-operation discards the op and any pending response; no response is emitted.
//  States: IDLE, EXEC, RESP.
//  Acceptance:
//  - A request is accepted when req_valid[i] & req_ready[i].
//  - req_ready is combinational and only asserted in IDLE, or in RESP while rsp_ready=1.
//  - It goes to the winner only.
//  Arbitration:
//  - One valid requester: it wins.
//  - Both valid, FIXED_PRIO=0: the requester != last_grant wins.
//  - Both valid, FIXED_PRIO=1: requester 0 wins.
//  - last_grant updates on acceptance only.
//  IDLE:
//  - On acceptance: latch op/A/B/id into the alu_* registers; go to EXEC.
//  - Otherwise stay in IDLE; alu_* hold their last values.
//  EXEC (exactly 1 cycle):
//  - The ALU settles combinationally from the registered pins.
//  - At the closing edge, capture into the rsp_* registers:
//    - rsp_r = alu_r.
//    - rsp_cout / rsp_ovr = alu_cout / alu_ovr, masked to 0 when op[1]=1.
//    - zero/neg computed from alu_r.
//  - Set rsp_valid=1; go to RESP.
//  RESP:
//  - rsp_* are held stable while rsp_valid=1 & rsp_ready=0 (no change, no drop).
//  - rsp_ready=1 with a new acceptance in the same cycle: load the new op; go to EXEC;
//    rsp_valid falls next cycle (back-to-back).
//  - rsp_ready=1 with no request: rsp_valid falls; go to IDLE.
//  Latency and throughput:
//  - Acceptance edge N -> rsp_valid high after edge N+1 (visible in cycle N+2).
//  - Peak throughput 1 op / 2 cycles.
//  Arithmetic:
//  - WIDTH-bit, two's complement.
//  - Wrap-around results (e.g. 7+1 = 8 = -8) are reported as-is, with ovr/cout from the ALU.
//  Boundary rules:
//  - req_valid dropping without acceptance is legal and has no effect.
//  - Requester inputs are sampled only at acceptance.
// TESTING
//  1. Reset then req0 add A=3,B=4 -> req_ready0 same cycle;
//     2 cycles later rsp_valid=1, id=0, r=7, cout=0, ovr=0, zero=0, neg=0.
//  2. req1 add A=7,B=1 -> r=8 (0x8), ovr=1, neg=1, cout=0.
//     req1 sub A=5,B=5 -> r=0, zero=1.
//  3. req0 xor A=0xF,B=0xF -> r=0, zero=1, cout=0, ovr=0 (masked even if the ALU pins
//     toggle). and A=0xC,B=0xA -> r=0x8, neg=1.
//  4. Both valid continuously, FIXED_PRIO=0, rsp_ready=1 -> grants alternate 0,1,0,1;
//     one rsp every 2 cycles. With FIXED_PRIO=1 -> all grants go to 0.
//  5. Hold rsp_ready=0 for 5 cycles with req1 valid -> rsp_* stable, req_ready=00.
//     Release -> req1 accepted in the same cycle.
//  6. Assert rst during EXEC and during RESP -> all outputs 0 immediately, no response.
//     Next tie is granted to requester 0.

Source files
------------

// File: rtl/alu_sched.sv
// alu_sched: shares one external combinational 4-op ALU between two requesters.
// The granted request is registered onto the ALU pins, the result is captured
// one cycle later into a held response, and the response is released under
// valid/ready backpressure. Back-to-back operation gives one op every 2 cycles.

// Two-way arbiter: round-robin on lastGrant, or requester 0 always first.
module alu_sched_arb #(
    parameter int FIXED_PRIO = 0
) (
    input  logic [1:0] reqValid,
    input  logic       lastGrant,
    input  logic       enable,
    output logic [1:0] grant
);
    localparam logic fixedPrio = (FIXED_PRIO != 0);

    logic pick0;

    // Requester 0 wins when alone, under fixed priority, or when it is its turn
    always_comb begin
        pick0 = reqValid[0] & (~reqValid[1] | fixedPrio | lastGrant);
        grant = 2'b00;
        if (enable) begin
            grant = {reqValid[1] & ~pick0, pick0};
        end
    end
endmodule

// Response flag derivation from the raw ALU pins.
module alu_sched_flags #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] aluR,
    input  logic             aluCout,
    input  logic             aluOvr,
    input  logic             logicOp,
    output logic             cout,
    output logic             ovr,
    output logic             zero,
    output logic             neg
);
    // and/xor leave carry/overflow undefined on the ALU pins, so force them low
    always_comb begin
        cout = aluCout & ~logicOp;
        ovr  = aluOvr & ~logicOp;
        zero = (aluR == '0);
        neg  = aluR[WIDTH-1];
    end
endmodule

module alu_sched #(
    parameter int WIDTH      = 4,
    parameter int FIXED_PRIO = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0]       req_op0,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [1:0]       req_op1,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_s0,
    output logic             alu_s1,
    input  logic [WIDTH-1:0] alu_r,
    input  logic             alu_cout,
    input  logic             alu_ovr,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_r,
    output logic             rsp_cout,
    output logic             rsp_ovr,
    output logic             rsp_zero,
    output logic             rsp_neg,
    output logic             busy
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    typedef struct packed {
        logic [1:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             id;
    } reqT;

    logic [1:0] state;
    logic       lastGrant;
    logic       curId;
    logic       canAccept;
    logic [1:0] grant;
    logic       accept;
    reqT        sel;
    logic       fCout;
    logic       fOvr;
    logic       fZero;
    logic       fNeg;

    // A slot is free in IDLE, or in RESP when the held response leaves this cycle
    assign canAccept = (state == IDLE) | ((state == RESP) & rsp_ready);

    alu_sched_arb #(
        .FIXED_PRIO(FIXED_PRIO)
    ) uArb (
        .reqValid (req_valid),
        .lastGrant(lastGrant),
        .enable   (canAccept),
        .grant    (grant)
    );

    assign req_ready = grant;
    assign accept    = |(req_valid & grant);
    assign busy      = (state != IDLE);

    // Mux the winning requester's fields; only used on an accepting cycle
    always_comb begin
        sel = '{op: req_op0, a: req_a0, b: req_b0, id: 1'b0};
        if (grant[1]) begin
            sel = '{op: req_op1, a: req_a1, b: req_b1, id: 1'b1};
        end
    end

    alu_sched_flags #(
        .WIDTH(WIDTH)
    ) uFlags (
        .aluR   (alu_r),
        .aluCout(alu_cout),
        .aluOvr (alu_ovr),
        .logicOp(alu_s1),
        .cout   (fCout),
        .ovr    (fOvr),
        .zero   (fZero),
        .neg    (fNeg)
    );

    // Load the ALU pin registers and arbitration history on acceptance only
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_s0    <= 1'b0;
            alu_s1    <= 1'b0;
            curId     <= 1'b0;
            lastGrant <= 1'b1;
        end else if (accept) begin
            alu_a     <= sel.a;
            alu_b     <= sel.b;
            alu_s0    <= sel.op[0];
            alu_s1    <= sel.op[1];
            curId     <= sel.id;
            lastGrant <= sel.id;
        end
    end

    // Control FSM plus the held response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_r     <= '0;
            rsp_cout  <= 1'b0;
            rsp_ovr   <= 1'b0;
            rsp_zero  <= 1'b0;
            rsp_neg   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    // ALU pins have had a full cycle to settle from the registers
                    rsp_valid <= 1'b1;
                    rsp_id    <= curId;
                    rsp_r     <= alu_r;
                    rsp_cout  <= fCout;
                    rsp_ovr   <= fOvr;
                    rsp_zero  <= fZero;
                    rsp_neg   <= fNeg;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= accept ? EXEC : IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched: a round-robin instance and a fixed-priority
// instance share stimulus, each driving its own behavioural ALU model.
module tb_alu_sched;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] reqValid;
    logic [1:0] reqOp0, reqOp1;
    logic [3:0] reqA0, reqB0, reqA1, reqB1;
    logic       rspReady;

    logic [1:0] rrReqReady, fpReqReady;
    logic [3:0] rrAluA, rrAluB, fpAluA, fpAluB;
    logic       rrAluS0, rrAluS1, fpAluS0, fpAluS1;
    logic [3:0] rrAluR, fpAluR;
    logic       rrAluCout, rrAluOvr, fpAluCout, fpAluOvr;
    logic       rrRspValid, rrRspId, rrRspCout, rrRspOvr, rrRspZero, rrRspNeg, rrBusy;
    logic       fpRspValid, fpRspId, fpRspCout, fpRspOvr, fpRspZero, fpRspNeg, fpBusy;
    logic [3:0] rrRspR, fpRspR;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_sched #(.WIDTH(4), .FIXED_PRIO(0)) uRr (
        .clk(clk), .rst(rst), .req_valid(reqValid), .req_ready(rrReqReady),
        .req_op0(reqOp0), .req_a0(reqA0), .req_b0(reqB0),
        .req_op1(reqOp1), .req_a1(reqA1), .req_b1(reqB1),
        .alu_a(rrAluA), .alu_b(rrAluB), .alu_s0(rrAluS0), .alu_s1(rrAluS1),
        .alu_r(rrAluR), .alu_cout(rrAluCout), .alu_ovr(rrAluOvr),
        .rsp_valid(rrRspValid), .rsp_ready(rspReady), .rsp_id(rrRspId),
        .rsp_r(rrRspR), .rsp_cout(rrRspCout), .rsp_ovr(rrRspOvr),
        .rsp_zero(rrRspZero), .rsp_neg(rrRspNeg), .busy(rrBusy)
    );

    alu_sched #(.WIDTH(4), .FIXED_PRIO(1)) uFp (
        .clk(clk), .rst(rst), .req_valid(reqValid), .req_ready(fpReqReady),
        .req_op0(reqOp0), .req_a0(reqA0), .req_b0(reqB0),
        .req_op1(reqOp1), .req_a1(reqA1), .req_b1(reqB1),
        .alu_a(fpAluA), .alu_b(fpAluB), .alu_s0(fpAluS0), .alu_s1(fpAluS1),
        .alu_r(fpAluR), .alu_cout(fpAluCout), .alu_ovr(fpAluOvr),
        .rsp_valid(fpRspValid), .rsp_ready(rspReady), .rsp_id(fpRspId),
        .rsp_r(fpRspR), .rsp_cout(fpRspCout), .rsp_ovr(fpRspOvr),
        .rsp_zero(fpRspZero), .rsp_neg(fpRspNeg), .busy(fpBusy)
    );

    // Behavioural ALU returning {cout, ovr, r}; logic ops drive junk carry/ovr high
    function automatic logic [5:0] aluModel(input logic [3:0] a, input logic [3:0] b,
                                            input logic s1, input logic s0);
        logic [4:0] sum;
        logic [3:0] r;
        logic       c, v;
        sum = 5'd0;
        case ({s1, s0})
            2'b00: begin
                sum = {1'b0, a} + {1'b0, b};
                r = sum[3:0]; c = sum[4];
                v = (a[3] == b[3]) && (r[3] != a[3]);
            end
            2'b01: begin
                sum = {1'b0, a} + {1'b0, ~b} + 5'd1;
                r = sum[3:0]; c = sum[4];
                v = (a[3] != b[3]) && (r[3] != a[3]);
            end
            2'b10: begin r = a & b; c = 1'b1; v = 1'b1; end
            default: begin r = a ^ b; c = 1'b1; v = 1'b1; end
        endcase
        return {c, v, r};
    endfunction

    always_comb {rrAluCout, rrAluOvr, rrAluR} = aluModel(rrAluA, rrAluB, rrAluS1, rrAluS0);
    always_comb {fpAluCout, fpAluOvr, fpAluR} = aluModel(fpAluA, fpAluB, fpAluS1, fpAluS0);

    // {valid, id, r, cout, ovr, zero, neg}
    function automatic logic [9:0] mk(input logic id, input logic [3:0] r, input logic c,
                                      input logic v, input logic z, input logic n);
        return {1'b1, id, r, c, v, z, n};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single request, hold response one cycle, then consume it
    task automatic runOp(input string tag, input logic id, input logic [1:0] op,
                         input logic [3:0] a, input logic [3:0] b,
                         input logic [1:0] expReady, input logic [9:0] expRsp);
        rspReady = 1'b0;
        if (id) begin reqOp1 = op; reqA1 = a; reqB1 = b; reqValid = 2'b10; end
        else    begin reqOp0 = op; reqA0 = a; reqB0 = b; reqValid = 2'b01; end
        #2;
        chk({tag, "_ready"}, 32'(rrReqReady), 32'(expReady));
        tick();
        reqValid = 2'b00;
        chk({tag, "_pins"}, 32'({rrBusy, rrRspValid, rrAluA, rrAluB, rrAluS1, rrAluS0}),
            32'({1'b1, 1'b0, a, b, op}));
        tick();
        chk({tag, "_rsp"}, 32'({rrRspValid, rrRspId, rrRspR, rrRspCout, rrRspOvr, rrRspZero, rrRspNeg}),
            32'(expRsp));
        rspReady = 1'b1;
        tick();
        rspReady = 1'b0;
        chk({tag, "_drain"}, 32'({rrRspValid, rrBusy}), 32'(2'b00));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; reqValid = 2'b00; rspReady = 1'b0;
        reqOp0 = 2'b00; reqA0 = 4'h0; reqB0 = 4'h0;
        reqOp1 = 2'b00; reqA1 = 4'h0; reqB1 = 4'h0;
        #2;
        chk("reset_rr", 32'({rrReqReady, rrAluA, rrAluB, rrAluS0, rrAluS1, rrRspValid, rrRspId,
                             rrRspR, rrRspCout, rrRspOvr, rrRspZero, rrRspNeg, rrBusy}), 32'd0);
        chk("reset_fp", 32'({fpReqReady, fpAluA, fpAluB, fpRspValid, fpRspR, fpBusy}), 32'd0);
        tick();
        rst = 1'b0;

        // Basic ops, single requester
        runOp("t1_add", 1'b0, 2'b00, 4'h3, 4'h4, 2'b01, mk(1'b0, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0));
        runOp("t2_wrap", 1'b1, 2'b00, 4'h7, 4'h1, 2'b10, mk(1'b1, 4'h8, 1'b0, 1'b1, 1'b0, 1'b1));
        runOp("t2_sub0", 1'b1, 2'b01, 4'h5, 4'h5, 2'b10, mk(1'b1, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0));
        runOp("t3_xor", 1'b0, 2'b11, 4'hF, 4'hF, 2'b01, mk(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0));
        runOp("t3_and", 1'b0, 2'b10, 4'hC, 4'hA, 2'b01, mk(1'b0, 4'h8, 1'b0, 1'b0, 1'b0, 1'b1));

        // Both requesters valid continuously, consumer always ready
        rst = 1'b1;
        tick();
        rst = 1'b0;
        reqOp0 = 2'b00; reqA0 = 4'h1; reqB0 = 4'h1;
        reqOp1 = 2'b11; reqA1 = 4'h6; reqB1 = 4'h3;
        reqValid = 2'b11; rspReady = 1'b1;
        #2;
        chk("t4_first_rr", 32'(rrReqReady), 32'(2'b01));
        chk("t4_first_fp", 32'(fpReqReady), 32'(2'b01));
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("t4_exec", 32'({rrRspValid, rrReqReady}), 32'd0);
            tick();
            chk("t4_rsp_rr", 32'({rrRspValid, rrRspId, rrRspR}),
                32'({1'b1, k[0], (k[0] ? 4'h5 : 4'h2)}));
            chk("t4_rsp_fp", 32'({fpRspValid, fpRspId, fpRspR}), 32'({1'b1, 1'b0, 4'h2}));
            chk("t4_grant_rr", 32'(rrReqReady), 32'(k[0] ? 2'b01 : 2'b10));
            chk("t4_grant_fp", 32'(fpReqReady), 32'(2'b01));
            if (k == 3) reqValid = 2'b00;
            tick();
        end
        chk("t4_idle", 32'({rrBusy, fpBusy, rrRspValid}), 32'd0);

        // Backpressure: response held while req1 waits
        rspReady = 1'b0;
        reqOp0 = 2'b00; reqA0 = 4'h2; reqB0 = 4'h3; reqValid = 2'b01;
        #2;
        chk("t5_ready0", 32'(rrReqReady), 32'(2'b01));
        tick();
        reqValid = 2'b10; reqOp1 = 2'b01; reqA1 = 4'h9; reqB1 = 4'h2;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t5_hold_rsp", 32'({rrRspValid, rrRspId, rrRspR, rrRspCout, rrRspOvr, rrRspZero, rrRspNeg}),
                32'(mk(1'b0, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0)));
            chk("t5_hold_ready", 32'(rrReqReady), 32'd0);
            tick();
        end
        rspReady = 1'b1;
        #2;
        chk("t5_release", 32'(rrReqReady), 32'(2'b10));
        tick();
        reqValid = 2'b00; reqA1 = 4'h0; reqB1 = 4'h0;
        chk("t5_exec", 32'({rrRspValid, rrAluA, rrAluB, rrAluS1, rrAluS0}),
            32'({1'b0, 4'h9, 4'h2, 2'b01}));
        tick();
        chk("t5_rsp", 32'({rrRspValid, rrRspId, rrRspR, rrRspCout, rrRspOvr, rrRspZero, rrRspNeg}),
            32'(mk(1'b1, 4'h7, 1'b1, 1'b1, 1'b0, 1'b0)));
        tick();
        rspReady = 1'b0;
        chk("t5_idle", 32'({rrRspValid, rrBusy}), 32'd0);

        // Reset during EXEC
        reqOp0 = 2'b00; reqA0 = 4'h1; reqB0 = 4'h2; reqValid = 2'b01;
        tick();
        reqValid = 2'b00;
        rst = 1'b1;
        #1;
        chk("t6_rst_exec", 32'({rrReqReady, rrAluA, rrAluB, rrAluS0, rrAluS1, rrRspValid, rrRspId,
                                rrRspR, rrRspCout, rrRspOvr, rrRspZero, rrRspNeg, rrBusy}), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("t6_no_rsp_exec", 32'({rrRspValid, rrBusy}), 32'd0);

        // Reset during RESP
        reqValid = 2'b01;
        tick();
        reqValid = 2'b00;
        tick();
        chk("t6_resp_pre", 32'({rrRspValid, rrRspR}), 32'({1'b1, 4'h3}));
        rst = 1'b1;
        #1;
        chk("t6_rst_resp", 32'({rrReqReady, rrAluA, rrAluB, rrAluS0, rrAluS1, rrRspValid, rrRspId,
                                rrRspR, rrRspCout, rrRspOvr, rrRspZero, rrRspNeg, rrBusy}), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("t6_no_rsp_resp", 32'({rrRspValid, rrBusy}), 32'd0);

        // Last accepted was requester 0, but reset restores the tie to requester 0
        reqValid = 2'b11;
        #2;
        chk("t6_tie", 32'(rrReqReady), 32'(2'b01));
        reqValid = 2'b00;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
